// File: rtl/soc_system_led_pkg.sv
// Shared register map and STATUS bit positions for the LED PWM PIO.
// Latency: none (constants only); no backpressure.
package soc_system_led_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_MODE   = 3'd3;
    localparam logic [2:0] ADDR_PERIOD = 3'd4;
    localparam logic [2:0] ADDR_DUTY   = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int STATUS_PHASE  = 0;
    localparam int STATUS_PWM_ON = 1;

endpackage

// File: rtl/soc_system_led_tick_gen.sv
// Blink prescaler with phase flop plus free-running PWM counter and duty compare.
// Latency: PERIOD write reloads the counter one cycle after the write; no backpressure.
module soc_system_led_tick_gen #(
    parameter int CNT_W = 24,
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] period,
    input  logic             period_wr,
    input  logic [PWM_W-1:0] duty,
    output logic             phase,
    output logic             pwm_on
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PWM_W-1:0] PWM_ONE = PWM_W'(1);
    localparam logic [PWM_W-1:0] PWM_MAX = {PWM_W{1'b1}};

    logic             r_load;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic [PWM_W-1:0] r_pwm_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load    <= 1'b0;
            r_cnt     <= '0;
            r_phase   <= 1'b1;
            r_pwm_cnt <= '0;
        end else begin
            r_load    <= period_wr;
            r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
            // A zero period parks the blinker in the lit phase.
            if (period == '0) begin
                r_cnt   <= '0;
                r_phase <= 1'b1;
            end else if (r_load) begin
                r_cnt   <= period;
                r_phase <= 1'b1;
            end else if (r_cnt == '0) begin
                r_cnt   <= period;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt - CNT_ONE;
            end
        end
    end

    assign phase  = r_phase;
    assign pwm_on = (duty == PWM_MAX) | (r_pwm_cnt < duty);

endmodule

// File: rtl/soc_system_led_pwm_pio.sv
// Avalon-MM LED output PIO with SET/CLR, per-bit blink and global PWM dimming.
// Latency: zero-wait reads, write visible on out_port one edge later; never stalls the bus.
module soc_system_led_pwm_pio
    import soc_system_led_pkg::*;
#(
    parameter int               WIDTH      = 10,
    parameter int               CNT_W      = 24,
    parameter int               PWM_W      = 8,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             w_wr;
    logic             w_period_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_lit;
    logic             w_phase;
    logic             w_pwm_on;
    logic             w_unused;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_mode;
    logic [CNT_W-1:0] r_period;
    logic [PWM_W-1:0] r_duty;
    logic [WIDTH-1:0] r_out;

    assign w_wr        = chipselect & ~write_n;
    assign w_period_wr = w_wr & (address == ADDR_PERIOD);
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_unused    = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= RESET_DATA;
            r_mode   <= '0;
            r_period <= '0;
            r_duty   <= {PWM_W{1'b1}};
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:   r_data   <= w_wd;
                ADDR_SET:    r_data   <= r_data | w_wd;
                ADDR_CLR:    r_data   <= r_data & ~w_wd;
                ADDR_MODE:   r_mode   <= w_wd;
                ADDR_PERIOD: r_period <= writedata[CNT_W-1:0];
                ADDR_DUTY:   r_duty   <= writedata[PWM_W-1:0];
                default:     ;
            endcase
        end
    end

    soc_system_led_tick_gen #(
        .CNT_W (CNT_W),
        .PWM_W (PWM_W)
    ) u_tick_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .period    (r_period),
        .period_wr (w_period_wr),
        .duty      (r_duty),
        .phase     (w_phase),
        .pwm_on    (w_pwm_on)
    );

    // Read path is not gated by chipselect, matching the legacy PIO.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0] = r_data;
            ADDR_MODE:   readdata[WIDTH-1:0] = r_mode;
            ADDR_PERIOD: readdata[CNT_W-1:0] = r_period;
            ADDR_DUTY:   readdata[PWM_W-1:0] = r_duty;
            ADDR_STATUS: begin
                readdata[STATUS_PHASE]  = w_phase;
                readdata[STATUS_PWM_ON] = w_pwm_on;
            end
            default:     readdata = '0;
        endcase
    end

    assign w_lit = r_data & (~r_mode | {WIDTH{w_phase}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_lit & {WIDTH{w_pwm_on}};
        end
    end

    assign out_port = r_out;

endmodule

// File: tb/tb_soc_system_led_pwm_pio.sv
// Self-checking bench for soc_system_led_pwm_pio with a cycle-count based reference model.
module tb_soc_system_led_pwm_pio;

    localparam int               WIDTH      = 10;
    localparam int               CNT_W      = 24;
    localparam int               PWM_W      = 8;
    localparam logic [WIDTH-1:0] RESET_DATA = '0;
    localparam int               PWM_MAX    = (1 << PWM_W) - 1;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b1;
    logic [2:0]       address    = '0;
    logic             chipselect = 1'b0;
    logic             write_n    = 1'b1;
    logic [31:0]      writedata  = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    soc_system_led_pwm_pio #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .PWM_W      (PWM_W),
        .RESET_DATA (RESET_DATA)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    // Reference model: time is counted in edges since reset; the blink phase
    // is derived from the edge at which the current period took effect.
    logic [WIDTH-1:0] m_data, m_mode, m_out, m_lit;
    int unsigned      m_period, m_duty;
    int               m_cycle, m_anchor, m_p, m_pend_p;
    bit               m_pend, m_ph;

    function automatic bit m_phase_at(int s);
        if (m_p == 0) return 1'b1;
        return (((s - m_anchor) / (m_p + 1)) % 2) == 0;
    endfunction

    function automatic bit m_pwm_at(int s);
        return (m_duty == PWM_MAX) || ((s % (PWM_MAX + 1)) < int'(m_duty));
    endfunction

    function automatic logic [31:0] m_read(logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd3:    return 32'(m_mode);
            3'd4:    return m_period;
            3'd5:    return m_duty;
            3'd6:    return {30'd0, m_pwm_at(m_cycle), m_phase_at(m_cycle)};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data   = RESET_DATA;
            m_mode   = '0;
            m_period = 0;
            m_duty   = PWM_MAX;
            m_cycle  = 0;
            m_anchor = 0;
            m_p      = 0;
            m_pend   = 1'b0;
            m_pend_p = 0;
            m_out    = '0;
        end else begin
            m_ph = m_phase_at(m_cycle);
            for (int i = 0; i < WIDTH; i++)
                m_lit[i] = m_data[i] && (m_mode[i] ? m_ph : 1'b1);
            m_out = m_pwm_at(m_cycle) ? m_lit : '0;
            m_cycle++;
            if (m_pend) begin
                m_p      = m_pend_p;
                m_anchor = m_cycle;
                m_pend   = 1'b0;
            end
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[WIDTH-1:0];
                    3'd1: m_data = m_data | writedata[WIDTH-1:0];
                    3'd2: m_data = m_data & ~writedata[WIDTH-1:0];
                    3'd3: m_mode = writedata[WIDTH-1:0];
                    3'd4: begin
                        m_period = writedata & ((32'd1 << CNT_W) - 32'd1);
                        m_pend   = 1'b1;
                        m_pend_p = int'(m_period);
                    end
                    3'd5: m_duty = writedata & PWM_MAX;
                    default: ;
                endcase
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [31:0] exp_tab [8];
        exp_tab = '{32'(RESET_DATA), 32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h3, 32'h0};
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_port !== '0) begin
            errors++;
            $display("FAIL reset_out_during: got %h want 0", out_port);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            checks++;
            if (d !== exp_tab[a]) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %h want %h", a, d, exp_tab[a]);
            end
        end
        checks++;
        if (out_port !== '0) begin
            errors++;
            $display("FAIL reset_out_after: got %h want 0", out_port);
        end
    endtask

    task automatic test_set_clr;
        logic [31:0] d;
        wr(3'd0, 32'h3FF);
        wr(3'd1, 32'h000);
        wr(3'd2, 32'h00F);
        wr(3'd1, 32'h001);
        checks++;
        if (out_port !== 10'h3F0) begin
            errors++;
            $display("FAIL setclr_out_latency: got %h want 3f0", out_port);
        end
        rd(3'd0, d);
        checks++;
        if (d !== 32'h3F1) begin
            errors++;
            $display("FAIL setclr_data: got %h want 3f1", d);
        end
        checks++;
        if (out_port !== 10'h3F1) begin
            errors++;
            $display("FAIL setclr_out: got %h want 3f1", out_port);
        end
        wr(3'd0, 32'hFFFF_FFFF);
        rd(3'd0, d);
        checks++;
        if (d !== 32'h3FF) begin
            errors++;
            $display("FAIL data_wide_write: got %h want 3ff", d);
        end
        wr(3'd6, 32'h0);
        wr(3'd7, 32'h0);
        wr(3'd2, 32'h0);
        rd(3'd0, d);
        checks++;
        if (d !== 32'h3FF) begin
            errors++;
            $display("FAIL ro_write_effect: got %h want 3ff", d);
        end
        for (int a = 1; a <= 7; a += 6) begin
            rd(3'(a), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL wo_read[%0d]: got %h want 0", a, d);
            end
        end
    endtask

    task automatic test_blink;
        logic prev;
        int   last, ntog, per;
        wr(3'd3, 32'h001);
        wr(3'd4, 32'd3);
        wr(3'd0, 32'h001);
        for (int pass = 0; pass < 2; pass++) begin
            per  = (pass == 0) ? 4 : 2;
            prev = out_port[0];
            last = 0;
            ntog = 0;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                checks++;
                if (out_port !== m_out) begin
                    errors++;
                    $display("FAIL blink_model p%0d c%0d: got %h want %h", pass, c, out_port, m_out);
                end
                if (out_port[0] !== prev) begin
                    if (ntog >= 2) begin
                        checks++;
                        if (c - last != per) begin
                            errors++;
                            $display("FAIL blink_spacing p%0d: got %0d want %0d", pass, c - last, per);
                        end
                    end
                    ntog++;
                    last = c;
                    prev = out_port[0];
                end
            end
            checks++;
            if (out_port[WIDTH-1:1] !== '0 || ntog < 4) begin
                errors++;
                $display("FAIL blink_other_bits p%0d: got %h toggles %0d want 0 and >=4", pass, out_port, ntog);
            end
            if (pass == 0) wr(3'd4, 32'd1);
        end
    endtask

    task automatic test_pwm;
        int hi;
        wr(3'd3, 32'h0);
        wr(3'd0, 32'h3FF);
        wr(3'd5, 32'h40);
        @(negedge clk);
        hi = 0;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            checks++;
            if (out_port !== m_out || (out_port !== 10'h3FF && out_port !== 10'h000)) begin
                errors++;
                $display("FAIL pwm_model c%0d: got %h want %h", c, out_port, m_out);
            end
            if (out_port === 10'h3FF) hi++;
        end
        checks++;
        if (hi != 64) begin
            errors++;
            $display("FAIL pwm_duty_count: got %0d want 64", hi);
        end
        for (int k = 0; k < 2; k++) begin
            wr(3'd5, (k == 0) ? 32'h00 : 32'hFF);
            @(negedge clk);
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                checks++;
                if (out_port !== ((k == 0) ? 10'h000 : 10'h3FF)) begin
                    errors++;
                    $display("FAIL pwm_const k%0d c%0d: got %h", k, c, out_port);
                end
            end
        end
    endtask

    task automatic test_combined;
        wr(3'd0, $urandom);
        wr(3'd3, $urandom | 32'h1);
        wr(3'd5, 32'h80);
        wr(3'd4, 32'd255);
        for (int c = 0; c < 4096; c++) begin
            @(negedge clk);
            checks++;
            if (out_port !== m_out) begin
                errors++;
                $display("FAIL combined c%0d: got %h want %h", c, out_port, m_out);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic [31:0] exp_tab [8];
        exp_tab = '{32'(RESET_DATA), 32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h3, 32'h0};
        @(negedge clk);
        address = 3'd0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_port !== '0 || readdata !== 32'(RESET_DATA)) begin
            errors++;
            $display("FAIL midreset_async: out %h data %h want 0", out_port, readdata);
        end
        address = 3'd3;
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_mode: got %h want 0", readdata);
        end
        address = 3'd6;
        #1;
        checks++;
        if (readdata !== 32'h3) begin
            errors++;
            $display("FAIL midreset_status: got %h want 3", readdata);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            checks++;
            if (d !== exp_tab[a]) begin
                errors++;
                $display("FAIL postreset_read[%0d]: got %h want %h", a, d, exp_tab[a]);
            end
        end
        wr(3'd3, 32'h2AA);
        wr(3'd0, 32'h3FF);
        wr(3'd4, 32'd5);
        wr(3'd5, 32'h30);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            checks++;
            if (out_port !== m_out) begin
                errors++;
                $display("FAIL postreset_model c%0d: got %h want %h", c, out_port, m_out);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] exp;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            exp = m_read(address);
            checks++;
            if (out_port !== m_out || readdata !== exp) begin
                errors++;
                $display("FAIL random c%0d: out %h want %h rd %h want %h", c, out_port, m_out, readdata, exp);
            end
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            writedata  = (address == 3'd4) ? 32'($urandom_range(0, 6)) : $urandom;
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        test_reset();
        test_set_clr();
        test_blink();
        test_pwm();
        test_combined();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
